// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-granular sharing of one byte-wide UART TX
//            core among NUM_REQ requesters. Define UART_ARB_TAG_EN to prefix
//            every packet with a tag byte (TAG_BASE | grant_id).
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int         NUM_REQ  = 3,
    parameter int         MAX_PKT  = 64,
    parameter logic [7:0] TAG_BASE = 8'hA0
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       pkt_active,
    output logic                       pkt_overrun
);

    localparam int                 c_ID_W      = $clog2(NUM_REQ);
    localparam int                 c_CNT_W     = $clog2(MAX_PKT + 1);
    localparam logic [c_ID_W:0]    c_NUM_REQ_W = (c_ID_W + 1)'(NUM_REQ);
    localparam logic [c_ID_W-1:0]  c_LAST_ID   = c_ID_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT   = c_CNT_W'(MAX_PKT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3
`ifdef UART_ARB_TAG_EN
        ,
        ST_TAG       = 3'd4
`endif
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [7:0]          r_tx_data;
    logic                r_last;
    logic [c_CNT_W-1:0]  r_byte_cnt;
    logic                r_overrun;

    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   w_rr_nxt;
    logic [c_ID_W-1:0]   w_grant_nxt;
    logic [7:0]          w_data_nxt;
    logic                w_last_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_overrun_nxt;
    logic [NUM_REQ-1:0]  w_ready;

    logic                w_arb_found;
    logic [c_ID_W-1:0]   w_arb_idx;
    logic [c_ID_W:0]     w_arb_sum;
    logic [c_ID_W-1:0]   w_rr_after;

`ifndef UART_ARB_TAG_EN
    // The tag base only matters when tagging is compiled in.
    logic [7:0] w_unused_tag_base;
    assign w_unused_tag_base = TAG_BASE;
`endif

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_arb_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_arb_sum = {1'b0, r_rr_ptr} + (c_ID_W + 1)'(k);
            if (w_arb_sum >= c_NUM_REQ_W) begin
                w_arb_sum = w_arb_sum - c_NUM_REQ_W;
            end
            if (!w_arb_found && req_valid[w_arb_sum[c_ID_W-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_arb_sum[c_ID_W-1:0];
            end
        end
    end

    assign w_rr_after = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + c_ID_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_grant_nxt   = r_grant_id;
        w_data_nxt    = r_tx_data;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_byte_cnt;
        w_overrun_nxt = 1'b0;
        w_ready       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_grant_nxt = w_arb_idx;
`ifdef UART_ARB_TAG_EN
                    w_state_nxt = ST_TAG;
`else
                    w_state_nxt = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                // The grant stays locked here until the owner offers a byte.
                if (req_valid[r_grant_id]) begin
                    w_ready[r_grant_id] = 1'b1;
                    w_data_nxt          = req_data[{r_grant_id, 3'b000} +: 8];
                    w_last_nxt          = req_last[r_grant_id];
                    w_cnt_nxt           = r_byte_cnt + c_CNT_W'(1);
                    w_state_nxt         = ST_START;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                w_data_nxt  = TAG_BASE | 8'(r_grant_id);
                w_last_nxt  = 1'b0;
                w_state_nxt = ST_START;
            end
`endif
            ST_START: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_last || (r_byte_cnt == c_MAX_CNT)) begin
                        w_overrun_nxt = !r_last;
                        w_rr_nxt      = w_rr_after;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_last     <= 1'b0;
            r_byte_cnt <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_grant_id <= w_grant_nxt;
            r_tx_data  <= w_data_nxt;
            r_last     <= w_last_nxt;
            r_byte_cnt <= w_cnt_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    // A byte offered during reset must not be reported as taken.
    assign req_ready   = wb_rst_i ? '0 : w_ready;
    assign tx_start    = (r_state == ST_START);
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign pkt_active  = (r_state != ST_IDLE);
    assign pkt_overrun = r_overrun;

endmodule
`default_nettype wire
